// File: rtl/module_captura_pkg.sv
// Shared keypad definitions: key codes, capture FSM states, default operand width.
package pkg_teclado;

    localparam int unsigned DIGITS_DEF = 3;

    localparam logic [3:0] KEY_ACEPTAR = 4'hA;
    localparam logic [3:0] KEY_BORRAR  = 4'hB;
    localparam logic [3:0] KEY_LIMPIAR = 4'hC;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_DONE = 2'd2
    } captura_state_t;

    // Key codes 0x0-0x9 are decimal digits.
    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/module_captura_bcd_shift_reg.sv
// DIGITS-deep packed BCD entry register: push inserts at digit 0, pop drops digit 0.
module bcd_shift_reg #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst_in,
    input  logic                            clr,
    input  logic                            push,
    input  logic                            pop,
    input  logic [3:0]                      din,
    output logic [4*DIGITS-1:0]             value,
    output logic [$clog2(DIGITS+1)-1:0]     count
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    // Digit storage; a full register ignores pushes, an empty one ignores pops.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            value <= '0;
            count <= '0;
        end else if (clr) begin
            value <= '0;
            count <= '0;
        end else if (push && (count < CW'(DIGITS))) begin
            value <= (value << 4) | W'(din);
            count <= count + CW'(1);
        end else if (pop && (count != '0)) begin
            value <= value >> 4;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/module_captura.sv
// Assembles two BCD operands from keypad strobes and hands them off with valid/ack.
module module_captura
    import pkg_teclado::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                            clk,
    input  logic                            rst_in,
    input  logic [3:0]                      numero,
    input  logic                            save,
    output logic [4*DIGITS-1:0]             op_a,
    output logic [4*DIGITS-1:0]             op_b,
    output logic [4*DIGITS-1:0]             entry,
    output logic [$clog2(DIGITS+1)-1:0]     ndig,
    output logic                            sel_b,
    output logic                            valid,
    input  logic                            ack
);

    localparam int unsigned CW = $clog2(DIGITS + 1);

    captura_state_t state, state_d;
    logic           valid_d, sel_b_d;
    logic           save_q, armed, key_ev;
    logic           push_a, pop_a, push_b, pop_b, clr_all;
    logic [CW-1:0]  cnt_a, cnt_b;

    // A press counts only on a rising save seen after save was low at least once since reset.
    assign key_ev = save & ~save_q & armed;

    // Save edge detector and post-reset arming.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            save_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            save_q <= save;
            armed  <= armed | ~save;
        end
    end

    // State and handshake registers.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_A;
            valid <= 1'b0;
            sel_b <= 1'b0;
        end else begin
            state <= state_d;
            valid <= valid_d;
            sel_b <= sel_b_d;
        end
    end

    // Key decode and next state; clear and ack in S_DONE win over any other key.
    always_comb begin
        state_d = state;
        valid_d = valid;
        sel_b_d = sel_b;
        push_a  = 1'b0;
        pop_a   = 1'b0;
        push_b  = 1'b0;
        pop_b   = 1'b0;
        clr_all = 1'b0;
        if ((key_ev && (numero == KEY_LIMPIAR)) || ((state == S_DONE) && ack)) begin
            clr_all = 1'b1;
            state_d = S_A;
            valid_d = 1'b0;
            sel_b_d = 1'b0;
        end else if (key_ev) begin
            case (state)
                S_A: begin
                    if (is_digit(numero)) begin
                        push_a = 1'b1;
                    end else if (numero == KEY_BORRAR) begin
                        pop_a = 1'b1;
                    end else if (numero == KEY_ACEPTAR) begin
                        state_d = S_B;
                        sel_b_d = 1'b1;
                    end
                end
                S_B: begin
                    if (is_digit(numero)) begin
                        push_b = 1'b1;
                    end else if (numero == KEY_BORRAR) begin
                        pop_b = 1'b1;
                    end else if (numero == KEY_ACEPTAR) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    bcd_shift_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk    (clk),
        .rst_in (rst_in),
        .clr    (clr_all),
        .push   (push_a),
        .pop    (pop_a),
        .din    (numero),
        .value  (op_a),
        .count  (cnt_a)
    );

    bcd_shift_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk    (clk),
        .rst_in (rst_in),
        .clr    (clr_all),
        .push   (push_b),
        .pop    (pop_b),
        .din    (numero),
        .value  (op_b),
        .count  (cnt_b)
    );

    // Display view of the operand being typed.
    assign entry = (state == S_A) ? op_a : op_b;
    assign ndig  = (state == S_A) ? cnt_a : cnt_b;

endmodule
